rf_write_arbiter: RTL and testbench

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_write_arbiter_pkg.sv | 17 +
 rtl/rr_arb2.sv | 37 +++
 rtl/rf_write_arbiter.sv | 115 +++++++++++
 tb/tb_rf_write_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter:
// FSM states, requester identifiers and default geometry.
package rf_write_arbiter_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NREGS  = 32;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins at once, and on a
// conflict the requester not granted most recently wins.
module rr_arb2
    import rf_write_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic last_q;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (valid[REQ_ALU] && valid[REQ_LOAD]) begin
                grant = last_q ? 2'b01 : 2'b10;
            end else begin
                grant = valid;
            end
        end
    end

    // Reset leaves the pointer at the load unit, so the ALU wins the first conflict
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (grant[REQ_ALU]) begin
            last_q <= 1'b0;
        end else if (grant[REQ_LOAD]) begin
            last_q <= 1'b1;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write port arbiter: clears registers 1..NREGS-1 after reset,
// then merges ALU and load-unit writebacks through a registered write stage.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NREGS  = DEF_NREGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              init_busy,
    output logic [15:0]       conflict_cnt
);

    localparam logic [ADDR_W-1:0] INIT_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] INIT_LAST  = ADDR_W'(NREGS - 1);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] init_addr_q;
    logic              init_done_q;
    logic [1:0]        grant;
    logic              accept;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .enable (state_q == RUN && !rst),
        .valid  ({req1_valid, req0_valid}),
        .grant  (grant)
    );

    assign req0_ready = grant[REQ_ALU];
    assign req1_ready = grant[REQ_LOAD];
    assign init_busy  = (state_q == INIT);
    assign accept     = |grant;
    assign sel_addr   = grant[REQ_LOAD] ? req1_addr : req0_addr;
    assign sel_data   = grant[REQ_LOAD] ? req1_data : req0_data;

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    if (init_done_q) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Clear-sequence address; the done flag marks that the last register was issued
    always_ff @(posedge clk) begin
        if (rst) begin
            init_addr_q <= INIT_FIRST;
            init_done_q <= 1'b0;
        end else if (state_q == INIT && !init_done_q) begin
            if (init_addr_q == INIT_LAST) begin
                init_done_q <= 1'b1;
            end else begin
                init_addr_q <= init_addr_q + 1'b1;
            end
        end
    end

    // Register 0 is hardwired, so a granted write there is swallowed
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (state_q == INIT) begin
            wr_en <= !init_done_q;
            if (!init_done_q) begin
                wr_addr <= init_addr_q;
                wr_data <= '0;
            end
        end else begin
            wr_en <= 1'b0;
            if (accept && sel_addr != '0) begin
                wr_en   <= 1'b1;
                wr_addr <= sel_addr;
                wr_data <= sel_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (state_q == RUN && req0_valid && req1_valid && conflict_cnt != 16'hFFFF) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: directed stimulus pushes expected
// writes, a negedge monitor pops and compares every presented write.
module tb_rf_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          init_busy;
    logic [15:0]   conflict_cnt;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [AW-1:0] exp_addr_q[$];
    logic [DW-1:0] exp_data_q[$];
    int            grant_seq[4] = '{0, 1, 0, 1};

    rf_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NREGS(NR)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_addr    (req0_addr),
        .req0_data    (req0_data),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_addr    (req1_addr),
        .req1_data    (req1_data),
        .req1_ready   (req1_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .init_busy    (init_busy),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic expectWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
    endtask

    // Drives one cycle of inputs just after the rising edge
    task automatic applyStimulus(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                 input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                 input logic r);
        @(posedge clk);
        #1;
        rst        = r;
        req0_valid = v0;
        req0_addr  = a0;
        req0_data  = d0;
        req1_valid = v1;
        req1_addr  = a1;
        req1_data  = d1;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    // Called in the first cycle after reset release; returns in the first RUN cycle
    task automatic runInit();
        for (int k = 1; k < NR; k++) expectWrite(AW'(k), '0);
        #2;
        checkOutput("init_idle_wr_en", wr_en, 0);
        checkOutput("init_idle_busy", init_busy, 1);
        for (int i = 0; i < NR - 1; i++) begin
            @(posedge clk);
            #3;
            checkOutput("init_busy", init_busy, 1);
            checkOutput("init_ready0", req0_ready, 0);
            checkOutput("init_ready1", req1_ready, 0);
        end
        @(posedge clk);
        #3;
        checkOutput("init_done_busy", init_busy, 0);
    endtask

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_addr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write at %0t",
                         wr_addr, wr_data, $time);
            end else begin
                checkOutput("wr_addr", wr_addr, exp_addr_q.pop_front());
                checkOutput("wr_data", wr_data, exp_data_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;

        // Reset state, with both requesters knocking during reset
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        applyStimulus(1'b1, 5'd2, 32'h1, 1'b1, 5'd3, 32'h2, 1'b1);
        #2;
        checkOutput("rst_wr_en", wr_en, 0);
        checkOutput("rst_wr_addr", wr_addr, 0);
        checkOutput("rst_wr_data", wr_data, 0);
        checkOutput("rst_conflict_cnt", conflict_cnt, 0);
        checkOutput("rst_ready0", req0_ready, 0);
        checkOutput("rst_ready1", req1_ready, 0);
        applyIdle();
        runInit();

        // Single requesters
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0);
        #2;
        checkOutput("single0_ready0", req0_ready, 1);
        checkOutput("single0_ready1", req1_ready, 0);
        expectWrite(5'd5, 32'hDEADBEEF);
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd9, 32'h00009999, 1'b0);
        #2;
        checkOutput("single1_ready1", req1_ready, 1);
        checkOutput("single1_ready0", req0_ready, 0);
        expectWrite(5'd9, 32'h00009999);

        // Sustained conflict alternates grants
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 5'd3, 32'h11110003, 1'b1, 5'd7, 32'h22220007, 1'b0);
            #2;
            checkOutput("conflict_ready0", req0_ready, (grant_seq[i] == 0) ? 1 : 0);
            checkOutput("conflict_ready1", req1_ready, (grant_seq[i] == 1) ? 1 : 0);
            if (grant_seq[i] == 0) expectWrite(5'd3, 32'h11110003);
            else                   expectWrite(5'd7, 32'h22220007);
        end
        applyIdle();
        #2;
        checkOutput("conflict_cnt_4", conflict_cnt, 16'd4);

        // Write to register 0 consumes the grant without writing
        applyStimulus(1'b1, 5'd4, 32'h00000044, 1'b0, '0, '0, 1'b0);
        #2;
        checkOutput("pre_zero_ready0", req0_ready, 1);
        expectWrite(5'd4, 32'h00000044);
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd0, 32'h00000BAD, 1'b0);
        #2;
        checkOutput("zero_ready1", req1_ready, 1);
        applyStimulus(1'b1, 5'd12, 32'hAAAA000C, 1'b1, 5'd13, 32'hBBBB000D, 1'b0);
        #2;
        checkOutput("after_zero_ready0", req0_ready, 1);
        checkOutput("after_zero_ready1", req1_ready, 0);
        expectWrite(5'd12, 32'hAAAA000C);
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd13, 32'hBBBB000D, 1'b0);
        #2;
        checkOutput("held_ready1", req1_ready, 1);
        expectWrite(5'd13, 32'hBBBB000D);
        applyIdle();
        #2;
        checkOutput("conflict_cnt_5", conflict_cnt, 16'd5);

        // Reset pulse in RUN with a request pending
        applyStimulus(1'b1, 5'd20, 32'h00000020, 1'b0, '0, '0, 1'b0);
        #2;
        checkOutput("pre_rst_ready0", req0_ready, 1);
        expectWrite(5'd20, 32'h00000020);
        applyStimulus(1'b1, 5'd21, 32'h00000021, 1'b0, '0, '0, 1'b1);
        #2;
        checkOutput("rst_pulse_ready0", req0_ready, 0);
        checkOutput("rst_pulse_ready1", req1_ready, 0);
        applyStimulus(1'b1, 5'd21, 32'h00000021, 1'b0, '0, '0, 1'b0);
        checkOutput("rst_pulse_conflict_cnt", conflict_cnt, 0);
        runInit();
        checkOutput("post_init_ready0", req0_ready, 1);
        expectWrite(5'd21, 32'h00000021);

        // Counter saturation
        for (int i = 0; i < 65534; i++) begin
            applyStimulus(1'b1, '0, 32'h1, 1'b1, '0, 32'h2, 1'b0);
        end
        applyIdle();
        #2;
        checkOutput("conflict_cnt_fffe", conflict_cnt, 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, '0, 32'h1, 1'b1, '0, 32'h2, 1'b0);
        end
        applyIdle();
        #2;
        checkOutput("conflict_cnt_sat", conflict_cnt, 16'hFFFF);
        applyIdle();
        #2;
        checkOutput("conflict_cnt_hold", conflict_cnt, 16'hFFFF);

        applyIdle();
        applyIdle();
        checkOutput("scoreboard_drain", exp_addr_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
